// File: rtl/ptp_ts_queue_pkg.sv
// Shared constants and record layout for the PTP timestamp queue.
package ptp_ts_queue_pkg;

    // Read-port word indices
    localparam logic [2:0] TSQ_W_NS   = 3'd0;
    localparam logic [2:0] TSQ_W_SECL = 3'd1;
    localparam logic [2:0] TSQ_W_SECH = 3'd2;
    localparam logic [2:0] TSQ_W_ID   = 3'd3;
    localparam logic [2:0] TSQ_W_STAT = 3'd4;

    localparam int unsigned TSQ_REC_W = 116;

    // One stored timestamp record; timestamp is {seconds[47:0], nanoseconds[31:0]}
    typedef struct packed {
        logic [3:0]  msg_type;
        logic [15:0] seq_id;
        logic [15:0] frac_ns;
        logic [79:0] timestamp;
    } ts_rec_t;

endpackage

// File: rtl/ptp_ts_queue_if.sv
// Capture strobe plus software read/pop port of the timestamp queue.
interface ptp_ts_queue_if;

    logic        ts_valid_i;
    logic [79:0] ts_timestamp_i;
    logic [15:0] ts_frac_ns_i;
    logic [15:0] ts_seqId_i;
    logic [3:0]  ts_messageType_i;
    logic [2:0]  rd_sel_i;
    logic [31:0] rd_data_o;
    logic        pop_i;
    logic        clr_ovf_i;
    logic [3:0]  count_o;
    logic        empty_o;
    logic        full_o;
    logic        int_ts_o;

    modport master (
        output ts_valid_i, ts_timestamp_i, ts_frac_ns_i, ts_seqId_i, ts_messageType_i,
        output rd_sel_i, pop_i, clr_ovf_i,
        input  rd_data_o, count_o, empty_o, full_o, int_ts_o
    );

    modport slave (
        input  ts_valid_i, ts_timestamp_i, ts_frac_ns_i, ts_seqId_i, ts_messageType_i,
        input  rd_sel_i, pop_i, clr_ovf_i,
        output rd_data_o, count_o, empty_o, full_o, int_ts_o
    );

endinterface

// File: rtl/ptp_ts_fifo.sv
// Register FIFO with pointer+count bookkeeping and a synchronous flush.
module ptp_ts_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned W     = 116
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DepthCnt);
    assign count = cnt_q;
    assign rdata = mem[rd_ptr_q];

    // A pop frees the slot a same-cycle push needs when full
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Next pointers/count; flush overrides any push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
            if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; it is never visible while empty
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ptp_ts_queue.sv
// Timestamp record queue: message filter, overflow tracking and word-select read port.
module ptp_ts_queue
    import ptp_ts_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic              rtc_clk,
    input  logic              rtc_rst_n,
    input  logic              dis_ptpv2_i,
    input  logic [15:0]       msg_mask_i,
    ptp_ts_queue_if.slave     bus
);

    ts_rec_t     wr_rec, head;
    logic [AW:0] fifo_cnt;
    logic        fifo_full, fifo_empty;
    logic        push_req, ovf_event;
    logic        ovf_flag_q;
    logic [7:0]  ovf_cnt_q;
    logic [31:0] rd_data_d, rd_data_q;

    assign wr_rec = {bus.ts_messageType_i, bus.ts_seqId_i, bus.ts_frac_ns_i, bus.ts_timestamp_i};
    assign push_req = bus.ts_valid_i & msg_mask_i[bus.ts_messageType_i] & ~dis_ptpv2_i;
    // Full implies non-empty, so any pop makes room for the push
    assign ovf_event = push_req & fifo_full & ~bus.pop_i;

    ptp_ts_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (TSQ_REC_W)
    ) u_fifo (
        .clk   (rtc_clk),
        .rst_n (rtc_rst_n),
        .flush (dis_ptpv2_i),
        .push  (push_req),
        .pop   (bus.pop_i),
        .wdata (wr_rec),
        .rdata (head),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.count_o  = 4'(fifo_cnt);
    assign bus.empty_o  = fifo_empty;
    assign bus.full_o   = fifo_full;
    assign bus.int_ts_o = ~fifo_empty;
    assign bus.rd_data_o = rd_data_q;

    // Sticky overflow flag and saturating drop counter; clear beats a coincident drop
    always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
        if (!rtc_rst_n) begin
            ovf_flag_q <= 1'b0;
            ovf_cnt_q  <= 8'h00;
        end else if (bus.clr_ovf_i) begin
            ovf_flag_q <= 1'b0;
            ovf_cnt_q  <= 8'h00;
        end else if (ovf_event) begin
            ovf_flag_q <= 1'b1;
            if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'h01;
        end
    end

    // Read word mux over the current head; record words read 0 while empty
    always_comb begin
        rd_data_d = 32'h0;
        case (bus.rd_sel_i)
            TSQ_W_NS:   if (!fifo_empty) rd_data_d = head.timestamp[31:0];
            TSQ_W_SECL: if (!fifo_empty) rd_data_d = head.timestamp[63:32];
            TSQ_W_SECH: if (!fifo_empty) rd_data_d = {head.frac_ns, head.timestamp[79:64]};
            TSQ_W_ID:   if (!fifo_empty) rd_data_d = {12'h0, head.msg_type, head.seq_id};
            TSQ_W_STAT: rd_data_d = {16'h0, ovf_cnt_q, 2'b00, fifo_full, ovf_flag_q,
                                     bus.count_o};
            default:    rd_data_d = 32'h0;
        endcase
    end

    // Registered read data, one cycle behind rd_sel_i
    always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
        if (!rtc_rst_n) rd_data_q <= 32'h0;
        else            rd_data_q <= rd_data_d;
    end

endmodule

// File: tb/tb_ptp_ts_queue.sv
// Directed bench for ptp_ts_queue with a queue-based reference model.
module tb_ptp_ts_queue;

    localparam int DEPTH = 4;

    logic        rtc_clk = 1'b0;
    logic        rtc_rst_n = 1'b0;
    logic        dis = 1'b0;
    logic [15:0] msg_mask = 16'h000F;

    ptp_ts_queue_if bus ();

    ptp_ts_queue #(.DEPTH(DEPTH), .AW(2)) dut (
        .rtc_clk     (rtc_clk),
        .rtc_rst_n   (rtc_rst_n),
        .dis_ptpv2_i (dis),
        .msg_mask_i  (msg_mask),
        .bus         (bus.slave)
    );

    always #5 rtc_clk = ~rtc_clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    typedef struct {
        bit [47:0] sec;
        bit [31:0] ns;
        bit [15:0] frac;
        bit [15:0] seq;
        bit [3:0]  typ;
    } rec_t;

    rec_t        m_q[$];
    bit          m_ovf = 1'b0;
    bit [7:0]    m_cnt = 8'h00;
    logic [31:0] m_rd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [2:0] sel);
        rec_t h;
        bit   is_full;
        is_full = (m_q.size() == DEPTH);
        if (sel == 3'd4)
            return {16'h0, m_cnt, 2'b00, is_full, m_ovf, 4'(m_q.size())};
        if (sel > 3'd4 || m_q.size() == 0) return 32'h0;
        h = m_q[0];
        case (sel)
            3'd0:    return h.ns;
            3'd1:    return h.sec[31:0];
            3'd2:    return {h.frac, h.sec[47:32]};
            default: return {12'h0, h.typ, h.seq};
        endcase
    endfunction

    // Reference model: applies the queue rules once per clock
    always @(posedge rtc_clk or negedge rtc_rst_n) begin
        if (!rtc_rst_n) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_cnt = 8'h00;
            m_rd  = 32'h0;
        end else begin
            bit   push_req;
            bit   popped;
            bit   ov;
            rec_t r;
            ov = 1'b0;
            m_rd = word_of(bus.rd_sel_i);
            push_req = bus.ts_valid_i && msg_mask[bus.ts_messageType_i] && !dis;
            if (dis) begin
                m_q.delete();
            end else begin
                popped = bus.pop_i && (m_q.size() > 0);
                ov = push_req && (m_q.size() == DEPTH) && !popped;
                if (popped) void'(m_q.pop_front());
                if (push_req && !ov) begin
                    r.sec  = bus.ts_timestamp_i[79:32];
                    r.ns   = bus.ts_timestamp_i[31:0];
                    r.frac = bus.ts_frac_ns_i;
                    r.seq  = bus.ts_seqId_i;
                    r.typ  = bus.ts_messageType_i;
                    m_q.push_back(r);
                end
            end
            if (bus.clr_ovf_i) begin
                m_ovf = 1'b0;
                m_cnt = 8'h00;
            end else if (ov) begin
                m_ovf = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge rtc_clk) begin
        if (chk_en) begin
            chk("count", 32'(bus.count_o), 32'(m_q.size()));
            chk("empty", 32'(bus.empty_o), 32'(m_q.size() == 0));
            chk("full", 32'(bus.full_o), 32'(m_q.size() == DEPTH));
            chk("int_ts", 32'(bus.int_ts_o), 32'(m_q.size() != 0));
            chk("rd_data", bus.rd_data_o, m_rd);
        end
    end

    task automatic push_rec(input bit [3:0] typ, input bit [47:0] sec, input bit [31:0] ns,
                            input bit [15:0] frac, input bit [15:0] seq,
                            input bit pop, input bit clr);
        bus.ts_valid_i       = 1'b1;
        bus.ts_messageType_i = typ;
        bus.ts_timestamp_i   = {sec, ns};
        bus.ts_frac_ns_i     = frac;
        bus.ts_seqId_i       = seq;
        bus.pop_i            = pop;
        bus.clr_ovf_i        = clr;
        @(negedge rtc_clk);
        bus.ts_valid_i = 1'b0;
        bus.pop_i      = 1'b0;
        bus.clr_ovf_i  = 1'b0;
    endtask

    task automatic push(input bit [15:0] seq, input bit pop, input bit clr);
        push_rec(4'd0, 48'h0000_0001_0000 + 48'(seq), 32'h100 + 32'(seq), ~seq, seq, pop, clr);
    endtask

    task automatic pop_one();
        bus.pop_i = 1'b1;
        @(negedge rtc_clk);
        bus.pop_i = 1'b0;
    endtask

    task automatic rd_chk(input string name, input bit [2:0] sel, input logic [31:0] exp);
        bus.rd_sel_i = sel;
        @(negedge rtc_clk);
        chk(name, bus.rd_data_o, exp);
    endtask

    initial begin
        bus.ts_valid_i = 1'b0;
        bus.ts_timestamp_i = '0;
        bus.ts_frac_ns_i = '0;
        bus.ts_seqId_i = '0;
        bus.ts_messageType_i = '0;
        bus.rd_sel_i = 3'd0;
        bus.pop_i = 1'b0;
        bus.clr_ovf_i = 1'b0;
        repeat (2) @(negedge rtc_clk);
        rtc_rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_count", 32'(bus.count_o), 32'd0);
        chk("rst_empty", 32'(bus.empty_o), 32'd1);
        chk("rst_rd", bus.rd_data_o, 32'h0);

        // Basic capture and read
        push_rec(4'd0, 48'h0000_1234_5678, 32'h3B9A_C9FF, 16'hABCD, 16'h0042, 1'b0, 1'b0);
        chk("basic_count", 32'(bus.count_o), 32'd1);
        chk("basic_int", 32'(bus.int_ts_o), 32'd1);
        rd_chk("word0", 3'd0, 32'h3B9AC9FF);
        rd_chk("word1", 3'd1, 32'h12345678);
        rd_chk("word2", 3'd2, 32'hABCD0000);
        rd_chk("word3", 3'd3, 32'h00000042);
        rd_chk("word5", 3'd5, 32'h0);
        pop_one();

        // Message filter: Follow_Up not enabled
        push_rec(4'd8, 48'h1, 32'h2, 16'h3, 16'h0077, 1'b0, 1'b0);
        chk("filter_count", 32'(bus.count_o), 32'd0);
        rd_chk("filter_stat", 3'd4, 32'h0);
        rd_chk("empty_word0", 3'd0, 32'h0);

        // Fill and overflow
        for (int i = 1; i <= 6; i++) push(16'(i), 1'b0, 1'b0);
        chk("ovf_full", 32'(bus.full_o), 32'd1);
        rd_chk("ovf_stat", 3'd4, 32'h0000_0234);
        for (int i = 1; i <= 4; i++) begin
            rd_chk("ovf_order", 3'd3, 32'(i));
            pop_one();
        end
        chk("drain_empty", 32'(bus.empty_o), 32'd1);

        // Simultaneous push and pop when full, then when empty
        pop_one();
        push(16'd0, 1'b0, 1'b1);
        pop_one();
        for (int i = 10; i <= 13; i++) push(16'(i), 1'b0, 1'b0);
        push(16'd14, 1'b1, 1'b0);
        rd_chk("pp_full_stat", 3'd4, 32'h0000_0024);
        for (int i = 11; i <= 14; i++) begin
            rd_chk("pp_order", 3'd3, 32'(i));
            pop_one();
        end
        push(16'd20, 1'b1, 1'b0);
        rd_chk("pp_empty_stat", 3'd4, 32'h0000_0001);

        // Flush with three entries and one recorded overflow
        for (int i = 21; i <= 24; i++) push(16'(i), 1'b0, 1'b0);
        pop_one();
        rd_chk("pre_flush", 3'd4, 32'h0000_0113);
        dis = 1'b1;
        push(16'd30, 1'b0, 1'b0);
        chk("flush_count", 32'(bus.count_o), 32'd0);
        push(16'd31, 1'b0, 1'b0);
        rd_chk("flush_stat", 3'd4, 32'h0000_0110);
        dis = 1'b0;
        @(negedge rtc_clk);

        // Clear coincident with an overflow push
        for (int i = 40; i <= 43; i++) push(16'(i), 1'b0, 1'b0);
        push(16'd44, 1'b0, 1'b1);
        rd_chk("clr_win", 3'd4, 32'h0000_0024);
        rd_chk("clr_head", 3'd3, 32'h0000_0028);

        // Asynchronous reset mid-cycle with a full queue
        bus.rd_sel_i = 3'd4;
        #2;
        rtc_rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count_o), 32'd0);
        chk("arst_empty", 32'(bus.empty_o), 32'd1);
        chk("arst_full", 32'(bus.full_o), 32'd0);
        chk("arst_int", 32'(bus.int_ts_o), 32'd0);
        chk("arst_rd", bus.rd_data_o, 32'h0);
        @(negedge rtc_clk);
        rtc_rst_n = 1'b1;
        push(16'd50, 1'b0, 1'b0);
        rd_chk("post_rst", 3'd3, 32'h0000_0032);
        repeat (2) @(negedge rtc_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
